// File: rtl/regfile_sb_if.sv
// Bundle of the decode/issue read ports, the writeback write ports and the control
// inputs of the scoreboarded register file. The pipeline drives it as master.
interface regfile_sb_if #(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic                   stall;
  logic                   flush;
  logic [NUM_WR-1:0]      we;
  logic [NUM_WR*AW-1:0]   waddr;
  logic [NUM_WR*XLEN-1:0] wdata;
  logic [NUM_RD-1:0]      re;
  logic [NUM_RD*AW-1:0]   raddr;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_RD-1:0]      rbusy;
  logic                   hazard;
  logic                   iss_valid;
  logic [AW-1:0]          iss_rd;

  modport master (
    output stall, flush, we, waddr, wdata, re, raddr, iss_valid, iss_rd,
    input  rdata, rbusy, hazard
  );

  modport slave (
    input  stall, flush, we, waddr, wdata, re, raddr, iss_valid, iss_rd,
    output rdata, rbusy, hazard
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard (set at issue, cleared at writeback) for RAW hazard detection.
module regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [NUM_WR-1:0] wvalid;
  logic [AW-1:0]     wa [NUM_WR];
  logic [XLEN-1:0]   wd [NUM_WR];
  logic [AW-1:0]     ra [NUM_RD];
  logic [NUM_RD-1:0] byp_hit;

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    assign wa[i]     = bus.waddr[i*AW +: AW];
    assign wd[i]     = bus.wdata[i*XLEN +: XLEN];
    assign wvalid[i] = bus.we[i] & ~bus.stall & (wa[i] != '0);
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    assign ra[j] = bus.raddr[j*AW +: AW];
  end

  // NOTE: the architectural state must come up as zero, so the array is reset
  // explicitly; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      // Ascending loop: the last non-blocking update wins, i.e. the higher port.
      for (int i = 0; i < NUM_WR; i++) begin
        if (wvalid[i]) regs[wa[i]] <= wd[i];
      end
    end
  end

  // NOTE: busy_next is built with blocking assignments in a combinational block
  // (clear first, then set, so a new producer beats the retiring one); only the
  // flop below uses non-blocking assignments.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wvalid[i]) busy_next[wa[i]] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_rd != '0) busy_next[bus.iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      busy <= '0;
    end else if (!bus.stall) begin
      busy <= busy_next;
    end
  end

  // NOTE: every output gets a default before the loop so no latch is inferred
  // on the ports that are gated off.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    byp_hit   = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rst && bus.re[j] && ra[j] != '0) begin
        bus.rdata[j*XLEN +: XLEN] = regs[ra[j]];
        for (int i = 0; i < NUM_WR; i++) begin
          if (wvalid[i] && wa[i] == ra[j]) begin
            bus.rdata[j*XLEN +: XLEN] = wd[i];
            byp_hit[j] = 1'b1;
          end
        end
        bus.rbusy[j] = busy[ra[j]] & ~byp_hit[j];
      end
    end
  end

  assign bus.hazard = |(bus.rbusy & bus.re);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based reference
// model of the architectural registers and busy bits.
module tb_regfile_sb;
  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst           = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.we        = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.re        = '0;
    bus.raddr     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.we[p] = 1'b1;
    bus.waddr[p*AW +: AW]     = a;
    bus.wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.re[p] = 1'b1;
    bus.raddr[p*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = a;
  endtask

  // Port j sees: zero when gated, else the newest same-cycle write (highest port
  // index, not stalled) reported not-busy, else the stored value and its busy bit.
  task automatic exp_port(input int j, output logic [XLEN-1:0] d, output logic b);
    logic [AW-1:0] a;
    logic found;
    a = bus.raddr[j*AW +: AW];
    d = '0;
    b = 1'b0;
    if (!rst && a != 0 && bus.re[j]) begin
      d = m_regs[a];
      b = m_busy[a];
      found = 1'b0;
      for (int i = NUM_WR - 1; i >= 0; i--) begin
        if (!found && bus.we[i] && !bus.stall && bus.waddr[i*AW +: AW] == a) begin
          d = bus.wdata[i*XLEN +: XLEN];
          b = 1'b0;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge();
    logic [AW-1:0] a;
    logic [NREGS-1:0] nb;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      m_busy = '0;
    end else begin
      nb = m_busy;
      for (int i = 0; i < NUM_WR; i++) begin
        a = bus.waddr[i*AW +: AW];
        if (bus.we[i] && !bus.stall && a != 0) begin
          m_regs[a] = bus.wdata[i*XLEN +: XLEN];
          nb[a] = 1'b0;
        end
      end
      if (bus.iss_valid && bus.iss_rd != 0) nb[bus.iss_rd] = 1'b1;
      if (bus.flush) m_busy = '0;
      else if (!bus.stall) m_busy = nb;
    end
  endtask

  // Called right after a falling edge with inputs applied; checks all outputs
  // against the model, then lets one rising edge go by.
  task automatic step(input string tag);
    logic [XLEN-1:0] ed;
    logic eb;
    logic hz;
    #1;
    hz = 1'b0;
    for (int j = 0; j < NUM_RD; j++) begin
      exp_port(j, ed, eb);
      check($sformatf("%s rdata%0d", tag, j), bus.rdata[j*XLEN +: XLEN], ed);
      check($sformatf("%s rbusy%0d", tag, j), XLEN'(bus.rbusy[j]), XLEN'(eb));
      hz |= eb;
    end
    check($sformatf("%s hazard", tag), XLEN'(bus.hazard), XLEN'(hz));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
    idle();
    @(negedge clk);

    // Reset with writes pending: everything discarded.
    for (int c = 0; c < 2; c++) begin
      idle();
      rst = 1'b1;
      set_wr(0, 5'd3, 64'hBB);
      set_wr(1, 5'd5, 64'hAA);
      set_rd(0, 5'd3);
      set_rd(1, 5'd5);
      step("reset");
    end
    idle();
    set_rd(0, 5'd3);
    set_rd(1, 5'd5);
    #1;
    check("post-reset x3", bus.rdata[0 +: XLEN], 64'h0);
    check("post-reset x5", bus.rdata[XLEN +: XLEN], 64'h0);
    step("post-reset");

    // Plain write then read; x0 writes discarded.
    idle();
    set_wr(0, 5'd7, 64'h1234);
    step("wr x7");
    idle();
    set_rd(0, 5'd7);
    #1;
    check("x7 readback", bus.rdata[0 +: XLEN], 64'h1234);
    step("rd x7");
    idle();
    set_wr(0, 5'd0, 64'hFF);
    set_rd(1, 5'd0);
    step("wr x0");
    idle();
    set_rd(1, 5'd0);
    #1;
    check("x0 reads zero", bus.rdata[XLEN +: XLEN], 64'h0);
    step("rd x0");

    // Dual write to x9: higher port wins, both in bypass and in storage.
    idle();
    set_wr(0, 5'd9, 64'h11);
    set_wr(1, 5'd9, 64'h22);
    set_rd(0, 5'd9);
    #1;
    check("x9 bypass port1", bus.rdata[0 +: XLEN], 64'h22);
    step("dual wr x9");
    idle();
    set_rd(0, 5'd9);
    step("rd x9");

    // Same with stall: no bypass, no update.
    idle();
    bus.stall = 1'b1;
    set_wr(0, 5'd9, 64'h33);
    set_wr(1, 5'd9, 64'h44);
    set_rd(0, 5'd9);
    #1;
    check("x9 stalled no bypass", bus.rdata[0 +: XLEN], 64'h22);
    step("stall wr x9");
    idle();
    set_rd(0, 5'd9);
    #1;
    check("x9 unchanged after stall", bus.rdata[0 +: XLEN], 64'h22);
    step("rd x9 post-stall");

    // Scoreboard set at issue, cleared by writeback with bypass.
    idle();
    issue(5'd4);
    step("issue x4");
    idle();
    set_rd(0, 5'd4);
    #1;
    check("x4 busy", XLEN'(bus.rbusy[0]), 64'h1);
    check("x4 hazard", XLEN'(bus.hazard), 64'h1);
    step("rd x4 busy");
    idle();
    set_rd(0, 5'd4);
    set_wr(1, 5'd4, 64'h55);
    #1;
    check("x4 wb not busy", XLEN'(bus.rbusy[0]), 64'h0);
    check("x4 wb bypass", bus.rdata[0 +: XLEN], 64'h55);
    step("wb x4");
    idle();
    set_rd(0, 5'd4);
    step("rd x4 cleared");

    // Issue beats writeback on the same register.
    idle();
    issue(5'd6);
    step("issue x6");
    idle();
    issue(5'd6);
    set_wr(0, 5'd6, 64'h66);
    step("issue+wb x6");
    idle();
    set_rd(0, 5'd6);
    #1;
    check("x6 still busy", XLEN'(bus.rbusy[0]), 64'h1);
    step("rd x6");

    // Flush clears everything, including a same-cycle issue.
    foreach (m_regs[k]) begin end
    idle(); issue(5'd2);  step("issue x2");
    idle(); issue(5'd8);  step("issue x8");
    idle(); issue(5'd31); step("issue x31");
    idle();
    bus.flush = 1'b1;
    issue(5'd10);
    step("flush");
    idle(); set_rd(0, 5'd2);  set_rd(1, 5'd8);  step("rd x2 x8");
    idle(); set_rd(0, 5'd31); set_rd(1, 5'd10); step("rd x31 x10");
    idle(); set_rd(0, 5'd6);  set_rd(1, 5'd4);  step("rd x6 x4");

    // Randomized traffic on a narrow address range to force collisions.
    for (int c = 0; c < 400; c++) begin
      idle();
      rst       = ($urandom_range(0, 59) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_WR; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(i, AW'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      for (int j = 0; j < NUM_RD; j++) begin
        bus.re[j] = ($urandom_range(0, 3) != 0);
        bus.raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 1) issue(AW'($urandom_range(0, 7)));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the core's 2R1W integer register file.
- Generalised to NUM_RD read ports and NUM_WR write ports, with write-to-read bypass and a per-register busy scoreboard.
- The scoreboard is set at issue and cleared at writeback, so decode can detect RAW hazards without scanning the pipeline.
- Sits between decode/issue (read + issue ports) and writeback (write ports); honours the pipeline stall vector bit used for writeback.

Parameters:
XLEN, 64, register data width
NREGS, 32, number of architectural registers; x0 hardwired zero
AW, 5, register address width; must equal clog2(NREGS)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  writeback stall; freezes register writes and scoreboard updates
flush  in  1  pipeline flush; clears all busy bits
we  in  NUM_WR  per-port write enable
waddr  in  NUM_WR*AW  packed write addresses, port i at [i*AW +: AW]
wdata  in  NUM_WR*XLEN  packed write data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*AW  packed read addresses
rdata  out  NUM_RD*XLEN  packed read data (combinational)
rbusy  out  NUM_RD  per-port busy flag for the addressed register (combinational)
hazard  out  1  OR of (re[j] & rbusy[j]) over all read ports
iss_valid  in  1  issue of an instruction that will write iss_rd
iss_rd  in  AW  destination register of the issuing instruction

Behaviour:
- Reset (rst=1 at a clock edge):
  - All NREGS registers load 0; all busy bits clear.
  - While rst=1: rdata=0, rbusy=0, hazard=0.
- Write, per port i:
  - Condition: we[i] & ~stall & waddr_i!=0 & ~rst.
  - Effect: regs[waddr_i] <= wdata_i at next edge; one-cycle write latency.
  - Two ports, same address, same cycle: the higher port index wins.
  - Writes to x0 are discarded.
- Read, per port j (combinational, zero latency), in priority order:
  - rst -> 0
  - raddr_j==0 -> 0
  - re[j]=0 -> 0
  - Bypass: highest-index write port i with we[i] & ~stall & waddr_i==raddr_j supplies wdata_i.
  - Otherwise regs[raddr_j].
  - No bypass while stall=1; the stored value is returned.
- Scoreboard, busy[NREGS] with busy[0] constant 0. Next-state priority at each edge:
  1. rst -> all clear.
  2. flush -> all clear. Any same-cycle issue or writeback is ignored for the scoreboard, but register writes still occur if not stalled.
  3. stall -> busy holds.
  4. Otherwise:
     - Each valid write port clears busy[waddr_i].
     - Then iss_valid & iss_rd!=0 sets busy[iss_rd].
     - Set beats clear on the same register in the same cycle (new producer outstanding).
- rbusy_j:
  - Formula: busy[raddr_j] & ~(any write port i valid this cycle, i.e. we[i] & ~stall, with waddr_i==raddr_j).
  - A register being written this cycle is reported not-busy because bypass supplies it.
  - rbusy_j=0 when raddr_j==0 or re[j]=0.
- hazard:
  - Combinational OR of the rbusy terms.
  - Decode stalls on hazard=1; this block does not generate stall.
- No internal counters wrap. Reset asserted mid-operation (pending busy bits, in-flight writes) discards everything at that edge.

Test Plan:
- Reset: rst=1 for 2 cycles with we=2'b11, waddr={5,3}, wdata={AA,BB} -> after reset regs read 0 on ports 0/1 for x3,x5; rbusy=0.
- Write/read and x0:
  - we[0]=1, waddr0=7, wdata0=0x1234 -> next cycle raddr0=7 gives 0x1234.
  - waddr0=0, wdata0=0xFF -> raddr1=0 gives 0.
- Bypass and port priority:
  - we=2'b11, waddr0=waddr1=9, wdata0=0x11, wdata1=0x22, raddr0=9 same cycle -> rdata0=0x22; next cycle regs[9]=0x22.
  - Same stimulus with stall=1 -> rdata0=old x9 and x9 unchanged after the edge.
- Scoreboard set/clear:
  - iss_valid=1, iss_rd=4 -> next cycle raddr0=4, re0=1 gives rbusy0=1, hazard=1.
  - Then we[1]=1, waddr1=4 -> same cycle rbusy0=0 with bypassed data; next cycle busy[4]=0.
- Set-vs-clear collision: busy[6]=1, one cycle with iss_rd=6 and we[0]=1, waddr0=6 -> after the edge busy[6]=1.
- Flush: busy set on x2, x8, x31, flush=1 for one cycle while iss_rd=10 -> all busy bits 0 afterwards, including x10.
